// File: rtl/div_job_sequencer_if.sv
// div_job_sequencer_if
// Bundles the job input handshake, the divider control/operand bus and the
// result output handshake of div_job_sequencer.
//   in_valid/in_ready/in_a/in_b        : job offer (a = dividend, b = divisor)
//   div_ld_a/div_ld_b/div_start        : one-cycle control pulses to the divider
//   div_a/div_b                        : operands held for the divider
//   div_q/div_ov                       : divider result
//   out_valid/out_ready/out_q/out_ov/out_dbz : result handshake
// The slave modport is the sequencer itself; the master modport is the
// surrounding environment (job producer, divider and result consumer).
interface div_job_sequencer_if;
  logic       in_valid;
  logic       in_ready;
  logic [9:0] in_a;
  logic [9:0] in_b;
  logic       div_ld_a;
  logic       div_ld_b;
  logic       div_start;
  logic [9:0] div_a;
  logic [9:0] div_b;
  logic [9:0] div_q;
  logic       div_ov;
  logic       out_valid;
  logic       out_ready;
  logic [9:0] out_q;
  logic       out_ov;
  logic       out_dbz;

  modport slave (
    input  in_valid, in_a, in_b, div_q, div_ov, out_ready,
    output in_ready, div_ld_a, div_ld_b, div_start, div_a, div_b,
           out_valid, out_q, out_ov, out_dbz
  );

  modport master (
    output in_valid, in_a, in_b, div_q, div_ov, out_ready,
    input  in_ready, div_ld_a, div_ld_b, div_start, div_a, div_b,
           out_valid, out_q, out_ov, out_dbz
  );
endinterface

// File: rtl/div_job_sequencer.sv
// div_job_sequencer
// Operand-side sequencer in front of the 10-bit fixed-point divider. Jobs
// (a, b) are buffered in a 2-entry FIFO, loaded into the divider, started,
// and the result is captured after LATENCY cycles and offered on a
// valid/ready output. A zero divisor is answered locally (q = 3FF, ov = 1,
// dbz = 1) and never starts the divider.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : div_job_sequencer_if.slave (job input, divider bus, result output)
// Parameter:
//   LATENCY : cycles from div_start to valid div_q/div_ov, 1..15
module div_job_sequencer #(
  parameter int LATENCY = 14
) (
  input logic                clk,
  input logic                rst,
  div_job_sequencer_if.slave bus
);

  typedef enum logic [2:0] {IDLE, LOAD, START, WAIT, DONE} state_t;

  localparam logic [3:0] WAIT_INIT = 4'(LATENCY - 1);

  state_t      state;
  logic [19:0] fifo_mem [2];
  logic        wr_ptr;
  logic        rd_ptr;
  logic [1:0]  count;
  logic [3:0]  wait_cnt;
  logic        push;
  logic        pop;
  logic [9:0]  head_a;
  logic [9:0]  head_b;

  // in_ready comes only from registered occupancy (plus reset gating), so
  // there is no combinational path from in_valid.
  assign bus.in_ready = ~rst & (count != 2'd2);
  assign push         = bus.in_valid & bus.in_ready;
  // The head is consumed on the edge that leaves LOAD.
  assign pop          = (state == LOAD);
  assign {head_a, head_b} = fifo_mem[rd_ptr];

  // Storage needs no reset: occupancy decides what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= {bus.in_a, bus.in_b};
    end
  end

  // FIFO pointers and occupancy; push and pop can coincide when not full.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        wr_ptr <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Control FSM. Every output is registered, so strobes are set on the edge
  // that enters their state and cleared on the edge that leaves it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      wait_cnt      <= 4'd0;
      bus.div_ld_a  <= 1'b0;
      bus.div_ld_b  <= 1'b0;
      bus.div_start <= 1'b0;
      bus.div_a     <= 10'd0;
      bus.div_b     <= 10'd0;
      bus.out_valid <= 1'b0;
      bus.out_q     <= 10'd0;
      bus.out_ov    <= 1'b0;
      bus.out_dbz   <= 1'b0;
    end else begin
      bus.div_ld_a  <= 1'b0;
      bus.div_ld_b  <= 1'b0;
      bus.div_start <= 1'b0;
      case (state)
        IDLE: begin
          if (count != 2'd0) begin
            bus.div_ld_a <= 1'b1;
            bus.div_ld_b <= 1'b1;
            bus.div_a    <= head_a;
            bus.div_b    <= head_b;
            state        <= LOAD;
          end
        end
        LOAD: begin
          // div_b already holds the head divisor loaded on entry to LOAD.
          if (bus.div_b == 10'd0) begin
            bus.out_q     <= 10'h3FF;
            bus.out_ov    <= 1'b1;
            bus.out_dbz   <= 1'b1;
            bus.out_valid <= 1'b1;
            state         <= DONE;
          end else begin
            bus.div_start <= 1'b1;
            state         <= START;
          end
        end
        START: begin
          wait_cnt <= WAIT_INIT;
          state    <= WAIT;
        end
        WAIT: begin
          if (wait_cnt == 4'd0) begin
            bus.out_q     <= bus.div_q;
            bus.out_ov    <= bus.div_ov;
            bus.out_dbz   <= 1'b0;
            bus.out_valid <= 1'b1;
            state         <= DONE;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            state         <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_job_sequencer.sv
// tb_div_job_sequencer
// Self-checking bench for div_job_sequencer. A divider model answers start
// pulses exactly LATENCY cycles later (driving the inverse value at all other
// times), a queue-based scoreboard predicts every result in order, and the
// directed sequence pins latencies, pulses and literal results.
module tb_div_job_sequencer;

  localparam int LATENCY = 14;

  typedef struct packed {
    logic [9:0] q;
    logic       ov;
    logic       dbz;
  } exp_t;

  logic clk = 1'b0;
  logic rst;

  int checks    = 0;
  int failures  = 0;
  int cyc       = 0;
  int acc_cyc   = 0;
  int valid_cyc = 0;
  exp_t exp_q[$];

  int         ld_a_cnt  = 0;
  int         ld_b_cnt  = 0;
  int         start_cnt = 0;
  int         rise_cnt  = 0;
  int         xfer_cnt  = 0;
  int         ld_cyc    = 0;
  int         start_cyc = 0;
  logic [9:0] ld_a_val  = '0;
  logic [9:0] ld_b_val  = '0;
  logic       mon_prev_valid = 1'b0;

  logic       dv_active = 1'b0;
  int         dcnt      = 0;
  logic [9:0] dv_q      = '0;
  logic       dv_ov     = 1'b0;

  div_job_sequencer_if bus();

  div_job_sequencer #(.LATENCY(LATENCY)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference divider arithmetic: q = a*64/b, overflow when it exceeds 10 bits.
  function automatic logic [10:0] divModel(input logic [9:0] a, input logic [9:0] b);
    logic [31:0] full;
    full = (b == 10'd0) ? 32'd0 : (({22'd0, a} * 32'd64) / {22'd0, b});
    return {full > 32'd1023, full[9:0]};
  endfunction

  function automatic exp_t expResult(input logic [9:0] a, input logic [9:0] b);
    exp_t       e;
    logic [10:0] r;
    if (b == 10'd0) begin
      e.q = 10'h3FF; e.ov = 1'b1; e.dbz = 1'b1;
    end else begin
      r = divModel(a, b);
      e.q = r[9:0]; e.ov = r[10]; e.dbz = 1'b0;
    end
    return e;
  endfunction

  // Divider model: result valid only in the cycle LATENCY cycles after start.
  always @(negedge clk or posedge rst) begin
    if (rst) begin
      dv_active <= 1'b0;
      dcnt      <= 0;
      dv_q      <= '0;
      dv_ov     <= 1'b0;
    end else if (bus.div_start) begin
      dv_active      <= 1'b1;
      dcnt           <= LATENCY;
      {dv_ov, dv_q}  <= divModel(bus.div_a, bus.div_b);
    end else if (dv_active) begin
      if (dcnt == 0) dv_active <= 1'b0;
      else           dcnt      <= dcnt - 1;
    end
  end

  assign bus.div_q  = (dv_active && dcnt == 0) ? dv_q  : ~dv_q;
  assign bus.div_ov = (dv_active && dcnt == 0) ? dv_ov : ~dv_ov;

  // Pulse / handshake monitor; the main sequence compares snapshots of these.
  always @(negedge clk) begin
    if (bus.div_ld_a) begin
      ld_a_cnt <= ld_a_cnt + 1;
      ld_cyc   <= cyc;
      ld_a_val <= bus.div_a;
    end
    if (bus.div_ld_b) begin
      ld_b_cnt <= ld_b_cnt + 1;
      ld_b_val <= bus.div_b;
    end
    if (bus.div_start) begin
      start_cnt <= start_cnt + 1;
      start_cyc <= cyc;
    end
    if (bus.out_valid && !mon_prev_valid) rise_cnt <= rise_cnt + 1;
    if (bus.out_valid && bus.out_ready)   xfer_cnt <= xfer_cnt + 1;
    mon_prev_valid <= bus.out_valid;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Scoreboard: expected results queued at acceptance, checked while valid.
  task automatic scoreboardLoop();
    bit prev_valid = 1'b0;
    bit prev_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_q.delete();
        prev_valid = 1'b0;
        prev_ready = 1'b0;
      end else begin
        if (prev_valid && !prev_ready) checkOutput("sb_valid_hold", bus.out_valid, 1);
        if (bus.out_valid) begin
          checkOutput("sb_result_pending", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) begin
            checkOutput("sb_out_q",   bus.out_q,   exp_q[0].q);
            checkOutput("sb_out_ov",  bus.out_ov,  exp_q[0].ov);
            checkOutput("sb_out_dbz", bus.out_dbz, exp_q[0].dbz);
            if (bus.out_ready) void'(exp_q.pop_front());
          end
        end
        if (bus.in_valid && bus.in_ready) exp_q.push_back(expResult(bus.in_a, bus.in_b));
        prev_valid = bus.out_valid;
        prev_ready = bus.out_ready;
      end
    end
  endtask

  task automatic offerJob(input logic [9:0] a, input logic [9:0] b);
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_valid = 1'b1;
  endtask

  task automatic waitAccept(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        acc_cyc      = cyc;
        ok           = 1'b1;
      end
    end
  endtask

  task automatic applyStimulus(input logic [9:0] a, input logic [9:0] b);
    bit ok;
    offerJob(a, b);
    waitAccept(50, ok);
    checkOutput("job_accepted", ok, 1);
    if (!ok) bus.in_valid = 1'b0;
  endtask

  task automatic waitValid(input int budget);
    bit ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid) begin
        ok        = 1'b1;
        valid_cyc = cyc;
      end
    end
    checkOutput("out_valid_seen", ok, 1);
  endtask

  task automatic waitDrain(input int budget);
    bit ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(posedge clk); #1;
      if (exp_q.size() == 0 && !bus.out_valid && !bus.in_valid) ok = 1'b1;
    end
    checkOutput("drained", ok, 1);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit ok;
    int s_ld_a, s_ld_b, s_start, s_rise, s_xfer;

    rst           = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.out_ready = 1'b0;
    fork
      scoreboardLoop();
    join_none
    #1 rst = 1'b1;
    #2;
    $display("[TB] reset");
    checkOutput("rst_in_ready",  bus.in_ready,  0);
    checkOutput("rst_out_valid", bus.out_valid, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    checkOutput("post_rst_in_ready", bus.in_ready, 1);
    checkOutput("post_rst_outputs", {bus.out_valid, bus.out_q, bus.out_ov, bus.out_dbz}, 0);
    @(posedge clk); #1;

    // Single job
    $display("[TB] single job");
    bus.out_ready = 1'b1;
    s_ld_a = ld_a_cnt; s_ld_b = ld_b_cnt; s_start = start_cnt;
    applyStimulus(10'h100, 10'h080);
    waitValid(40);
    checkOutput("single_latency", valid_cyc - acc_cyc, 17);
    checkOutput("single_out_q",   bus.out_q,   10'h080);
    checkOutput("single_out_ov",  bus.out_ov,  0);
    checkOutput("single_out_dbz", bus.out_dbz, 0);
    @(posedge clk); #1;
    checkOutput("single_valid_fall", bus.out_valid, 0);
    checkOutput("single_ld_a_pulses", ld_a_cnt - s_ld_a, 1);
    checkOutput("single_ld_b_pulses", ld_b_cnt - s_ld_b, 1);
    checkOutput("single_start_pulses", start_cnt - s_start, 1);
    checkOutput("single_ld_timing", ld_cyc - acc_cyc, 1);
    checkOutput("single_start_after_ld", start_cyc - ld_cyc, 1);
    checkOutput("single_div_a", ld_a_val, 10'h100);
    checkOutput("single_div_b", ld_b_val, 10'h080);

    // Divide by zero
    $display("[TB] divide by zero");
    s_ld_a = ld_a_cnt; s_start = start_cnt;
    applyStimulus(10'h055, 10'h000);
    waitValid(20);
    checkOutput("dbz_latency", valid_cyc - acc_cyc, 2);
    checkOutput("dbz_out_q",   bus.out_q,   10'h3FF);
    checkOutput("dbz_out_ov",  bus.out_ov,  1);
    checkOutput("dbz_out_dbz", bus.out_dbz, 1);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("dbz_no_start", start_cnt - s_start, 0);
    checkOutput("dbz_ld_pulses", ld_a_cnt - s_ld_a, 1);
    checkOutput("dbz_div_a", ld_a_val, 10'h055);
    waitDrain(20);

    // Back-pressure and FIFO full
    $display("[TB] back-pressure");
    bus.out_ready = 1'b0;
    applyStimulus(10'h200, 10'h040);
    applyStimulus(10'h0C0, 10'h300);
    applyStimulus(10'h010, 10'h000);
    offerJob(10'h3FF, 10'h3FF);
    waitAccept(30, ok);
    checkOutput("bp_job4_stalled", ok, 0);
    checkOutput("bp_fifo_full_in_ready", bus.in_ready, 0);
    waitValid(40);
    for (int i = 0; i < 4; i++) begin
      checkOutput("bp_stall_out_q", bus.out_q, 10'h200);
      checkOutput("bp_stall_out_valid", bus.out_valid, 1);
      @(posedge clk); #1;
    end
    s_xfer = xfer_cnt;
    bus.out_ready = 1'b1;
    waitAccept(100, ok);
    checkOutput("bp_job4_accepted", ok, 1);
    if (!ok) bus.in_valid = 1'b0;
    waitDrain(300);
    checkOutput("bp_result_count", xfer_cnt - s_xfer, 4);

    // Overflow passthrough
    $display("[TB] overflow");
    applyStimulus(10'h3FF, 10'h001);
    waitValid(40);
    checkOutput("ov_out_q",   bus.out_q,   10'h3C0);
    checkOutput("ov_out_ov",  bus.out_ov,  1);
    checkOutput("ov_out_dbz", bus.out_dbz, 0);
    waitDrain(20);

    // Reset in the middle of WAIT with one job buffered
    $display("[TB] reset mid-wait");
    applyStimulus(10'h123, 10'h045);
    s_ld_a = acc_cyc;
    applyStimulus(10'h0AA, 10'h011);
    while (cyc < s_ld_a + 8) begin
      @(posedge clk); #1;
    end
    checkOutput("pre_rst_div_a", bus.div_a, 10'h123);
    #2 rst = 1'b1;
    #1;
    checkOutput("mid_rst_out_valid", bus.out_valid, 0);
    checkOutput("mid_rst_out_q",     bus.out_q,     0);
    checkOutput("mid_rst_out_flags", {bus.out_ov, bus.out_dbz}, 0);
    checkOutput("mid_rst_div_bus",
                {bus.div_ld_a, bus.div_ld_b, bus.div_start, bus.div_a, bus.div_b}, 0);
    checkOutput("mid_rst_in_ready",  bus.in_ready,  0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    checkOutput("rel_in_ready", bus.in_ready, 1);
    s_rise = rise_cnt; s_start = start_cnt;
    repeat (40) @(posedge clk);
    #1;
    checkOutput("rel_no_valid_rise", rise_cnt - s_rise, 0);
    checkOutput("rel_no_start", start_cnt - s_start, 0);
    checkOutput("rel_out_valid", bus.out_valid, 0);
    applyStimulus(10'h0F0, 10'h00F);
    waitValid(40);
    checkOutput("rel_latency", valid_cyc - acc_cyc, 17);
    checkOutput("rel_out_q",  bus.out_q,  10'h000);
    checkOutput("rel_out_ov", bus.out_ov, 1);
    waitDrain(20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
